// File: rtl/vga_fml_arbiter_if.sv
// Bus bundle between the VGA fetch, the CPU bridge, the FML controller and the arbiter.
// slave = arbiter view, master = the requesters and memory around it.
interface vga_fml_arbiter_if;
  logic [17:1] vid_adr_i;
  logic        vid_stb_i;
  logic        vid_ack_o;
  logic        vid_valid_o;
  logic [15:0] vid_dat_o;
  logic [17:1] cpu_adr_i;
  logic        cpu_stb_i;
  logic        cpu_we_i;
  logic [1:0]  cpu_sel_i;
  logic [15:0] cpu_dat_i;
  logic [15:0] cpu_dat_o;
  logic        cpu_ack_o;
  logic [17:1] fml_adr_o;
  logic        fml_stb_o;
  logic        fml_we_o;
  logic [1:0]  fml_sel_o;
  logic [15:0] fml_do_o;
  logic [15:0] fml_di_i;
  logic        fml_ack_i;
  logic [1:0]  grant_o;

  modport slave (
    input  vid_adr_i, vid_stb_i, cpu_adr_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_dat_i,
           fml_di_i, fml_ack_i,
    output vid_ack_o, vid_valid_o, vid_dat_o, cpu_dat_o, cpu_ack_o,
           fml_adr_o, fml_stb_o, fml_we_o, fml_sel_o, fml_do_o, grant_o
  );

  modport master (
    output vid_adr_i, vid_stb_i, cpu_adr_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_dat_i,
           fml_di_i, fml_ack_i,
    input  vid_ack_o, vid_valid_o, vid_dat_o, cpu_dat_o, cpu_ack_o,
           fml_adr_o, fml_stb_o, fml_we_o, fml_sel_o, fml_do_o, grant_o
  );
endinterface

// File: rtl/vga_fml_arbiter.sv
// Shares one burst FML port between VGA display fetch (priority) and the CPU bridge,
// with a streak limit so a waiting CPU gets a slot after MAX_VID_RUN video bursts.
module vga_fml_arbiter #(
  parameter int BURST_LEN   = 8,
  parameter int MAX_VID_RUN = 2
) (
  input logic              clk,
  input logic              rst,
  vga_fml_arbiter_if.slave bus
);
  localparam int CW = $clog2(BURST_LEN);
  localparam int SW = $clog2(MAX_VID_RUN + 1);
  localparam logic [SW-1:0] MAXR = SW'(MAX_VID_RUN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_grant;          // {cpu, vid}
  logic [CW-1:0] r_beat;
  logic [SW-1:0] r_streak;
  logic          r_gap;
  logic [17:1]   r_adr;
  logic          r_we;
  logic [1:0]    r_sel;
  logic [15:0]   r_dat;
  logic [15:0]   r_cpu_dat;
  logic          w_arb, w_pick_vid, w_pick_cpu, w_ack, w_last;

  // The IDLE cycle right after a burst is a turnaround slot: no arbitration in it.
  assign w_arb      = (r_state == IDLE) && !r_gap;
  assign w_pick_vid = bus.vid_stb_i && (!bus.cpu_stb_i || (r_streak < MAXR));
  assign w_pick_cpu = !w_pick_vid && bus.cpu_stb_i;
  assign w_ack      = (r_state == REQ) && bus.fml_ack_i;
  assign w_last     = (r_state == BURST) && (r_beat == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arb && (bus.vid_stb_i || bus.cpu_stb_i)) w_next = REQ;
      REQ:     if (bus.fml_ack_i) w_next = BURST;
      BURST:   if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant   <= '0;
      r_beat    <= '0;
      r_streak  <= '0;
      r_gap     <= 1'b0;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_dat     <= '0;
      r_cpu_dat <= '0;
    end else begin
      if (w_arb && w_pick_vid) begin
        r_grant  <= 2'b01;
        r_adr    <= bus.vid_adr_i;
        r_we     <= 1'b0;
        r_sel    <= 2'b11;
        r_dat    <= '0;
        // Only counts while the CPU is kept waiting; cannot pass MAXR here.
        r_streak <= bus.cpu_stb_i ? r_streak + 1'b1 : '0;
      end else if (w_arb && w_pick_cpu) begin
        r_grant  <= 2'b10;
        r_adr    <= bus.cpu_adr_i;
        r_we     <= bus.cpu_we_i;
        r_sel    <= bus.cpu_sel_i;
        r_dat    <= bus.cpu_dat_i;
        r_streak <= '0;
      end
      if (w_ack)                  r_beat <= CW'(1);
      else if (r_state == BURST)  r_beat <= r_beat + 1'b1;
      r_gap <= w_last;
      if (w_ack && r_grant[1] && !r_we) r_cpu_dat <= bus.fml_di_i;
    end
  end

  always_comb begin
    bus.grant_o     = '0;
    bus.fml_adr_o   = '0;
    bus.fml_stb_o   = 1'b0;
    bus.fml_we_o    = 1'b0;
    bus.fml_sel_o   = '0;
    bus.fml_do_o    = '0;
    bus.vid_ack_o   = 1'b0;
    bus.vid_valid_o = 1'b0;
    bus.vid_dat_o   = '0;
    bus.cpu_ack_o   = 1'b0;
    bus.cpu_dat_o   = r_cpu_dat;
    if (r_state != IDLE) begin
      bus.grant_o   = r_grant;
      bus.fml_adr_o = r_adr;
      bus.fml_stb_o = (r_state == REQ);
      bus.fml_we_o  = r_we;
      bus.fml_do_o  = r_dat;
      // CPU byte enables only on beat 0 so a write touches exactly one word.
      bus.fml_sel_o = ((r_state == REQ) || r_grant[0]) ? r_sel : 2'b00;
      if (r_grant[0]) begin
        bus.vid_ack_o   = w_ack;
        bus.vid_valid_o = w_ack || (r_state == BURST);
        bus.vid_dat_o   = bus.vid_valid_o ? bus.fml_di_i : '0;
      end else begin
        bus.cpu_ack_o = w_ack;
        if (w_ack && !r_we) bus.cpu_dat_o = bus.fml_di_i;
      end
    end
  end
endmodule

// File: tb/tb_vga_fml_arbiter.sv
// Directed + randomized bench for vga_fml_arbiter; the bench plays both requesters and the FML memory.
module tb_vga_fml_arbiter;
  localparam int BL = 8;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_fml_arbiter_if bus();

  vga_fml_arbiter #(.BURST_LEN(BL), .MAX_VID_RUN(MR)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cdat = '0;
  int          streak = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] bdat(input int i, input logic [15:0] d0,
                                       input logic [15:0] dn, input bit inc);
    if (inc) return d0 + 16'(i);
    return (i == 0) ? d0 : dn;
  endfunction

  // Serves one burst as the memory: waits for fml_stb_o, holds off ack for lat cycles,
  // then supplies BL beats and checks every requester-visible output on the way.
  task automatic do_burst(input string tag, input logic [1:0] own, input logic [17:1] adr,
                          input logic we, input logic [1:0] sel, input logic [15:0] wd,
                          input int lat, input int exp_w, input logic [15:0] d0,
                          input logic [15:0] dn, input bit inc, input bit drop);
    int w = 0;
    int nval = 0;
    bus.fml_ack_i = 1'b0;
    do begin @(negedge clk); #1; w++; end while (!bus.fml_stb_o && w < 40);
    if (!bus.fml_stb_o) begin chk({tag, ":stb_timeout"}, 0, 1); return; end
    if (exp_w > 0) chk({tag, ":stb_lat"}, w, exp_w);
    chk({tag, ":grant"}, bus.grant_o, own);
    chk({tag, ":adr"}, bus.fml_adr_o, adr);
    chk({tag, ":we"}, bus.fml_we_o, we);
    for (int k = 0; k < lat; k++) begin
      chk({tag, ":wait_quiet"}, {bus.vid_ack_o, bus.cpu_ack_o, bus.vid_valid_o}, 3'b000);
      @(negedge clk); #1;
      chk({tag, ":wait_stb_adr"}, {bus.fml_stb_o, bus.fml_adr_o}, {1'b1, adr});
    end
    bus.fml_ack_i = 1'b1;
    bus.fml_di_i  = bdat(0, d0, dn, inc);
    #1;
    nval += int'(bus.vid_valid_o);
    chk({tag, ":acks"}, {bus.vid_ack_o, bus.cpu_ack_o}, (own == 2'b01) ? 2'b10 : 2'b01);
    if (own == 2'b01) chk({tag, ":vdat0"}, bus.vid_dat_o, d0);
    else if (!we) chk({tag, ":cdat_ack"}, bus.cpu_dat_o, d0);
    else chk({tag, ":wr_beat0"}, {bus.fml_sel_o, bus.fml_do_o}, {sel, wd});
    for (int i = 1; i < BL; i++) begin
      @(negedge clk);
      bus.fml_ack_i = 1'b0;
      bus.fml_di_i  = bdat(i, d0, dn, inc);
      if (drop && i == 1) begin
        if (own == 2'b01) bus.vid_stb_i = 1'b0;
        else              bus.cpu_stb_i = 1'b0;
      end
      #1;
      nval += int'(bus.vid_valid_o);
      chk({tag, ":beat_grant"}, bus.grant_o, own);
      chk({tag, ":beat_quiet"}, {bus.fml_stb_o, bus.vid_ack_o, bus.cpu_ack_o}, 3'b000);
      if (own == 2'b01) chk({tag, ":vdat"}, bus.vid_dat_o, bdat(i, d0, dn, inc));
      else if (we) chk({tag, ":wr_sel"}, bus.fml_sel_o, 2'b00);
      else chk({tag, ":cdat_hold"}, bus.cpu_dat_o, d0);
    end
    if (own == 2'b10 && !we) exp_cdat = d0;
    @(negedge clk); #1;
    nval += int'(bus.vid_valid_o);
    chk({tag, ":end_idle"}, {bus.grant_o, bus.fml_stb_o}, 3'b000);
    chk({tag, ":end_cdat"}, bus.cpu_dat_o, exp_cdat);
    chk({tag, ":nvalid"}, nval, (own == 2'b01) ? BL : 0);
  endtask

  initial begin
    logic [1:0]  fair [6];
    logic [1:0]  own;
    int          w, ne, prev;
    int          e [3];
    logic [15:0] d0;

    bus.vid_adr_i = '0; bus.vid_stb_i = 1'b0;
    bus.cpu_adr_i = '0; bus.cpu_stb_i = 1'b0; bus.cpu_we_i = 1'b0;
    bus.cpu_sel_i = '0; bus.cpu_dat_i = '0;
    bus.fml_di_i  = '0; bus.fml_ack_i = 1'b0;

    // Reset state
    idle(3); #1;
    chk("rst:grant_stb", {bus.grant_o, bus.fml_stb_o}, 3'b000);
    chk("rst:outs", {bus.vid_valid_o, bus.vid_ack_o, bus.cpu_ack_o, bus.fml_sel_o, bus.fml_we_o},
        6'd0);
    chk("rst:adr_cdat", {bus.fml_adr_o, bus.cpu_dat_o}, 33'd0);
    @(negedge clk); rst = 1'b0;
    idle(2);

    // Video only, 3 wait cycles
    bus.vid_adr_i = 17'h00140; bus.vid_stb_i = 1'b1;
    do_burst("vid_only", 2'b01, 17'h00140, 1'b0, 2'b00, 16'h0, 3, 1, 16'h1000, 16'h0, 1'b1, 1'b1);
    idle(2);

    // CPU single-word write
    bus.cpu_adr_i = 17'h1ABCD; bus.cpu_we_i = 1'b1; bus.cpu_sel_i = 2'b10;
    bus.cpu_dat_i = 16'hBEEF; bus.cpu_stb_i = 1'b1;
    do_burst("cpu_wr", 2'b10, 17'h1ABCD, 1'b1, 2'b10, 16'hBEEF, 1, 1, 16'h0, 16'h0, 1'b0, 1'b1);
    idle(2);

    // CPU read: only beat 0 matters
    bus.cpu_adr_i = 17'h00777; bus.cpu_we_i = 1'b0; bus.cpu_sel_i = 2'b11; bus.cpu_stb_i = 1'b1;
    do_burst("cpu_rd", 2'b10, 17'h00777, 1'b0, 2'b11, 16'h0, 2, 1, 16'h55AA, 16'hFFFF, 1'b0, 1'b1);
    idle(3); #1;
    chk("cpu_rd:held", bus.cpu_dat_o, 16'h55AA);
    @(negedge clk);

    // Fairness with both requests held
    fair = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    bus.vid_adr_i = 17'h00200; bus.vid_stb_i = 1'b1;
    bus.cpu_adr_i = 17'h02000; bus.cpu_we_i = 1'b0; bus.cpu_stb_i = 1'b1;
    for (int k = 0; k < 6; k++)
      do_burst($sformatf("fair%0d", k), fair[k], (fair[k] == 2'b01) ? 17'h00200 : 17'h02000,
               1'b0, 2'b11, 16'h0, $urandom_range(0, 2), (k == 0) ? 1 : 2,
               16'hC000 + 16'(k), 16'h1111, 1'b0, 1'b0);
    bus.vid_stb_i = 1'b0; bus.cpu_stb_i = 1'b0;
    idle(3); #1;
    chk("fair:idle", {bus.grant_o, bus.fml_stb_o}, 3'b000);
    @(negedge clk);

    // Reset on beat 3 of a video burst
    bus.vid_adr_i = 17'h0ABC0; bus.vid_stb_i = 1'b1;
    w = 0;
    do begin @(negedge clk); #1; w++; end while (!bus.fml_stb_o && w < 40);
    chk("mrst:stb_seen", bus.fml_stb_o, 1'b1);
    bus.fml_ack_i = 1'b1; bus.fml_di_i = 16'h2000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); bus.fml_ack_i = 1'b0; bus.fml_di_i = 16'h2000 + 16'(k);
    end
    #1;
    chk("mrst:beat3_valid", bus.vid_valid_o, 1'b1);
    rst = 1'b1; bus.vid_stb_i = 1'b0;
    @(negedge clk); #1;
    exp_cdat = '0;
    chk("mrst:grant_stb", {bus.grant_o, bus.fml_stb_o}, 3'b000);
    chk("mrst:vid", {bus.vid_valid_o, bus.vid_ack_o, bus.vid_dat_o}, 18'd0);
    chk("mrst:fml", {bus.fml_adr_o, bus.fml_sel_o, bus.fml_we_o, bus.fml_do_o}, 36'd0);
    chk("mrst:cpu", {bus.cpu_ack_o, bus.cpu_dat_o}, 17'd0);
    rst = 1'b0;
    bus.cpu_adr_i = 17'h03030; bus.cpu_we_i = 1'b0; bus.cpu_stb_i = 1'b1;
    do_burst("post_rst", 2'b10, 17'h03030, 1'b0, 2'b11, 16'h0, 1, 1, 16'h3C3C, 16'h0, 1'b0, 1'b1);
    idle(2);

    // Back-to-back video with zero ack latency
    bus.vid_adr_i = 17'h00400; bus.vid_stb_i = 1'b1;
    ne = 0; prev = 0; e = '{0, 0, 0};
    for (int c = 0; c < 32; c++) begin
      @(negedge clk); bus.fml_ack_i = 1'b0; #1;
      if (bus.fml_stb_o && prev == 0 && ne < 3) begin e[ne] = c; ne++; end
      prev = int'(bus.fml_stb_o);
      bus.fml_ack_i = bus.fml_stb_o; bus.fml_di_i = 16'(c);
    end
    chk("b2b:edges", ne, 3);
    chk("b2b:period01", e[1] - e[0], BL + 2);
    chk("b2b:period12", e[2] - e[1], BL + 2);
    bus.vid_stb_i = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); bus.fml_ack_i = 1'b0; #1;
      bus.fml_ack_i = bus.fml_stb_o;
    end
    bus.fml_ack_i = 1'b0;
    #1;
    chk("b2b:idle", {bus.grant_o, bus.fml_stb_o}, 3'b000);
    idle(2);

    // Randomized mix against the arbitration rules
    streak = 0;
    for (int r = 0; r < 24; r++) begin
      if (!bus.vid_stb_i && $urandom_range(0, 1) == 1) begin
        bus.vid_stb_i = 1'b1; bus.vid_adr_i = 17'($urandom);
      end
      if (!bus.cpu_stb_i && $urandom_range(0, 1) == 1) begin
        bus.cpu_stb_i = 1'b1; bus.cpu_adr_i = 17'($urandom); bus.cpu_we_i = 1'($urandom);
        bus.cpu_sel_i = 2'($urandom); bus.cpu_dat_i = 16'($urandom);
      end
      if (!bus.vid_stb_i && !bus.cpu_stb_i) begin
        bus.vid_stb_i = 1'b1; bus.vid_adr_i = 17'($urandom);
      end
      if (bus.vid_stb_i && (!bus.cpu_stb_i || streak < MR)) begin
        own = 2'b01;
        streak = bus.cpu_stb_i ? ((streak + 1 > MR) ? MR : streak + 1) : 0;
      end else begin
        own = 2'b10;
        streak = 0;
      end
      d0 = 16'($urandom);
      if (own == 2'b01)
        do_burst($sformatf("rnd%0d", r), own, bus.vid_adr_i, 1'b0, 2'b00, 16'h0,
                 $urandom_range(0, 3), (r == 0) ? 1 : 2, d0, 16'h0, 1'b1, 1'b1);
      else
        do_burst($sformatf("rnd%0d", r), own, bus.cpu_adr_i, bus.cpu_we_i, bus.cpu_sel_i,
                 bus.cpu_dat_i, $urandom_range(0, 3), (r == 0) ? 1 : 2, d0, 16'(~d0), 1'b0, 1'b1);
    end
    bus.vid_stb_i = 1'b0; bus.cpu_stb_i = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
